pbit_group_scheduler: RTL and testbench
=======================================

PBIT_GROUP_SCHEDULER -- requirements
Module: pbit_group_scheduler

Interface
REQ-001 SHALL have parameter NUM_GROUPS, default 5, meaning the number of graph-colour update groups.
REQ-002 SHALL have parameter GROUP_W, default 3, meaning the width of the group select.
REQ-003 SHALL have parameter DWELL_W, default 8, meaning the width of the per-group dwell count.
REQ-004 SHALL have parameter SWEEP_W, default 16, meaning the width of the sweep counts.
REQ-005 SHALL have parameter BETA_W, default 4, meaning the width of the anneal (beta) step index.
REQ-006 SHALL use one clock and a synchronous, active-high reset, with ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a run; sampled in IDLE only.
- stop  in  1  abort the run.
- dwell_cycles  in  DWELL_W  cycles each group stays enabled; 0 is treated as 1.
- num_sweeps  in  SWEEP_W  sweeps per run.
- sweeps_per_beta  in  SWEEP_W  sweeps between beta steps; 0 means no stepping.
- group_EN  out  GROUP_W  group select to the Pbit_EN decode LUT.
- update_en  out  1  high while group_EN is a live update slot; downstream ANDs it with Pbit_EN.
- sample_valid  out  1  one-cycle pulse at each completed sweep.
- sweep_cnt  out  SWEEP_W  completed sweeps in the current or last run.
- beta_idx  out  BETA_W  current anneal step.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse at normal run completion.

Function
REQ-007 SHALL implement states IDLE, RUN and FINISH.
REQ-008 SHALL register dwell_cycles, num_sweeps and sweeps_per_beta when start is accepted, and SHALL ignore input changes during the run.
REQ-009 SHALL accept start only in IDLE; if stop is also high in that cycle, it SHALL stay in IDLE.
REQ-010 On an accepted start (cycle 0), SHALL clear sweep_cnt and beta_idx and, from cycle 1, SHALL drive:
- busy=1, update_en=1, group_EN=0 when num_sweeps!=0;
- otherwise it SHALL go to FINISH.
REQ-011 In RUN, SHALL hold each group for exactly max(dwell_cycles,1) cycles, then advance group_EN by 1.
REQ-012 After group NUM_GROUPS-1, in the cycle its dwell ends, SHALL:
- pulse sample_valid;
- increment sweep_cnt;
- wrap group_EN to 0.
REQ-013 SHALL increment beta_idx when sweeps_per_beta!=0 and the completed-sweep count is a multiple of sweeps_per_beta; beta_idx SHALL saturate at all-ones.
REQ-014 When the completed sweep makes sweep_cnt equal num_sweeps, SHALL go to FINISH with update_en=0.
REQ-015 FINISH SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-016 stop in RUN SHALL have priority over sweep and dwell events:
- next cycle IDLE, update_en=0, no done, no sample_valid;
- sweep_cnt and beta_idx hold their values.
REQ-017 In IDLE, SHALL drive group_EN=0 and update_en=0, and sweep_cnt and beta_idx SHALL hold the last values.
REQ-018 SHALL never enable two groups in the same cycle.
REQ-019 SHALL keep group_EN within 0..NUM_GROUPS-1 in all states.
REQ-020 sweep_cnt SHALL NOT wrap, because the run ends at num_sweeps ≤ 2^SWEEP_W-1.

Reset
REQ-021 rst SHALL override all inputs, including in the middle of a run.
REQ-022 On rst the block SHALL enter IDLE with group_EN=0 and update_en, sample_valid, busy, done, sweep_cnt, beta_idx and the dwell counter all 0.
REQ-023 The first start SHALL be accepted in the cycle after rst is deasserted.

Structure
REQ-024 A shared package (pbit_sched_pkg) SHALL hold the state enum and the NUM_GROUPS/GROUP_W defaults; the Pbit_EN LUT SHALL size from the same package.
REQ-025 The dwell counter SHALL be one sub-module, pbit_dwell_timer, with load, tick and expire ports; FSM and sweep/beta logic stay in the top.

Verification
REQ-026 dwell=1, num_sweeps=2, spb=0, start pulse:
- group_EN 0,1,2,3,4,0,1,2,3,4 on cycles 1-10;
- sample_valid at cycles 5 and 10;
- done at cycle 11;
- sweep_cnt=2, beta_idx=0.
REQ-027 dwell=3, num_sweeps=1: each group held 3 cycles, update_en high for 15 cycles, done at cycle 16.
REQ-028 dwell=0, num_sweeps=4, spb=2: behaves as dwell=1; beta_idx steps to 1 after sweep 2 and to 2 after sweep 4.
REQ-029 num_sweeps=0, start: no update_en, done at cycle 1, busy never high.
REQ-030 stop asserted during sweep 3 of 10: update_en low next cycle, no done, sweep_cnt=2 held; start with stop high in IDLE is ignored.
REQ-031 rst asserted mid-RUN, then start the cycle after release: all outputs at reset values, then a clean run from group 0.

Source files
------------

// File: rtl/pbit_sched_pkg.sv
// ----------------------------------------------------------------
// pbit_sched_pkg: shared state encoding and group-count defaults
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

package pbit_sched_pkg;

  // The Pbit_EN decode LUT sizes from these same defaults.
  localparam int DEF_NUM_GROUPS = 5;
  localparam int DEF_GROUP_W    = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_FINISH = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/pbit_dwell_timer.sv
// ----------------------------------------------------------------
// pbit_dwell_timer: down-counter marking the last cycle of a group dwell
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module pbit_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               tick,
  output logic               expire
);

  logic [DWELL_W-1:0] r_count;

  // load_val is always >= 1, so a count of zero marks the final dwell cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val - DWELL_W'(1);
    end else if (tick && (r_count != '0)) begin
      r_count <= r_count - DWELL_W'(1);
    end
  end

  assign expire = tick && (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/pbit_group_scheduler.sv
// ----------------------------------------------------------------
// pbit_group_scheduler: steps graph-colour update groups, counts sweeps, anneals beta
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module pbit_group_scheduler
  import pbit_sched_pkg::*;
#(
  parameter int NUM_GROUPS = DEF_NUM_GROUPS,
  parameter int GROUP_W    = DEF_GROUP_W,
  parameter int DWELL_W    = 8,
  parameter int SWEEP_W    = 16,
  parameter int BETA_W     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell_cycles,
  input  logic [SWEEP_W-1:0] num_sweeps,
  input  logic [SWEEP_W-1:0] sweeps_per_beta,
  output logic [GROUP_W-1:0] group_EN,
  output logic               update_en,
  output logic               sample_valid,
  output logic [SWEEP_W-1:0] sweep_cnt,
  output logic [BETA_W-1:0]  beta_idx,
  output logic               busy,
  output logic               done
);

  localparam logic [GROUP_W-1:0] c_last_group = GROUP_W'(NUM_GROUPS - 1);

  state_e             r_state;
  state_e             w_state_next;
  logic [DWELL_W-1:0] r_dwell;
  logic [SWEEP_W-1:0] r_num_sweeps;
  logic [SWEEP_W-1:0] r_spb;
  logic [SWEEP_W-1:0] r_sweep_cnt;
  logic [SWEEP_W-1:0] r_beta_cnt;
  logic [BETA_W-1:0]  r_beta;
  logic [GROUP_W-1:0] r_group;

  logic [DWELL_W-1:0] w_dwell_eff;
  logic [DWELL_W-1:0] w_timer_val;
  logic [SWEEP_W-1:0] w_sweep_next;
  logic [SWEEP_W-1:0] w_beta_cnt_next;
  logic               w_start_acc;
  logic               w_run;
  logic               w_expire;
  logic               w_advance;
  logic               w_last_group;
  logic               w_sweep_end;
  logic               w_run_done;
  logic               w_timer_load;

  assign w_dwell_eff     = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
  assign w_start_acc     = (r_state == S_IDLE) && start && !stop;
  assign w_run           = (r_state == S_RUN);
  // stop outranks every dwell/sweep event in the same cycle
  assign w_advance       = w_run && !stop && w_expire;
  assign w_last_group    = (r_group == c_last_group);
  assign w_sweep_end     = w_advance && w_last_group;
  assign w_sweep_next    = r_sweep_cnt + SWEEP_W'(1);
  assign w_run_done      = w_sweep_end && (w_sweep_next == r_num_sweeps);
  assign w_beta_cnt_next = r_beta_cnt + SWEEP_W'(1);
  assign w_timer_load    = w_start_acc || w_advance;
  assign w_timer_val     = w_start_acc ? w_dwell_eff : r_dwell;

  pbit_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (w_timer_load),
    .load_val (w_timer_val),
    .tick     (w_run),
    .expire   (w_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_acc) begin
          w_state_next = (num_sweeps == '0) ? S_FINISH : S_RUN;
        end
      end
      S_RUN: begin
        if (stop) begin
          w_state_next = S_IDLE;
        end else if (w_run_done) begin
          w_state_next = S_FINISH;
        end
      end
      S_FINISH: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    group_EN     = '0;
    update_en    = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    sample_valid = w_sweep_end;
    case (r_state)
      S_RUN: begin
        group_EN  = r_group;
        update_en = 1'b1;
        busy      = 1'b1;
      end
      S_FINISH: done = 1'b1;
      default: ;
    endcase
  end

  // Beta steps on a separate sweeps-since-last-step counter instead of a modulo.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dwell      <= '0;
      r_num_sweeps <= '0;
      r_spb        <= '0;
      r_sweep_cnt  <= '0;
      r_beta_cnt   <= '0;
      r_beta       <= '0;
      r_group      <= '0;
    end else if (w_start_acc) begin
      r_dwell      <= w_dwell_eff;
      r_num_sweeps <= num_sweeps;
      r_spb        <= sweeps_per_beta;
      r_sweep_cnt  <= '0;
      r_beta_cnt   <= '0;
      r_beta       <= '0;
      r_group      <= '0;
    end else if (w_run) begin
      if (stop) begin
        r_group <= '0;
      end else if (w_expire) begin
        r_group <= w_last_group ? '0 : r_group + GROUP_W'(1);
        if (w_last_group) begin
          r_sweep_cnt <= w_sweep_next;
          if (r_spb != '0) begin
            if (w_beta_cnt_next == r_spb) begin
              r_beta_cnt <= '0;
              if (r_beta != '1) begin
                r_beta <= r_beta + BETA_W'(1);
              end
            end else begin
              r_beta_cnt <= w_beta_cnt_next;
            end
          end
        end
      end
    end
  end

  assign sweep_cnt = r_sweep_cnt;
  assign beta_idx  = r_beta;

endmodule

`default_nettype wire

// File: tb/tb_pbit_group_scheduler.sv
// ----------------------------------------------------------------
// tb_pbit_group_scheduler: scoreboard bench with directed runs
// Rev 1.0
// ----------------------------------------------------------------
`default_nettype none

module tb_pbit_group_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        stop;
  logic [7:0]  dwell_cycles;
  logic [15:0] num_sweeps;
  logic [15:0] sweeps_per_beta;
  logic [2:0]  group_EN;
  logic        update_en;
  logic        sample_valid;
  logic [15:0] sweep_cnt;
  logic [3:0]  beta_idx;
  logic        busy;
  logic        done;

  pbit_group_scheduler dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .stop            (stop),
    .dwell_cycles    (dwell_cycles),
    .num_sweeps      (num_sweeps),
    .sweeps_per_beta (sweeps_per_beta),
    .group_EN        (group_EN),
    .update_en       (update_en),
    .sample_valid    (sample_valid),
    .sweep_cnt       (sweep_cnt),
    .beta_idx        (beta_idx),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int grp;
  } grp_t;

  typedef struct {
    bit is_done;
    int cyc;
    int sw;
    int beta;
  } evt_t;

  grp_t grp_q[$];
  evt_t evt_q[$];
  int   cyc = 0;
  int   t0  = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc - t0);
    end
  endtask

  task automatic push_grps(input int first, input int reps, input int total);
    for (int i = 0; i < total; i++) grp_q.push_back('{first + i, (i / reps) % 5});
  endtask

  task automatic push_evt(input bit d, input int c, input int sw, input int b);
    evt_q.push_back('{d, c, sw, b});
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an update slot or an event.
  always @(negedge clk) begin : mon
    int   k;
    grp_t g;
    evt_t e;
    k = cyc - t0;
    if (update_en === 1'b1) begin
      if (grp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL grp_unexpected: got group %0d at cycle %0d, required no update slot", group_EN, k);
      end else begin
        g = grp_q.pop_front();
        chk("grp_cycle", 32'(k), 32'(g.cyc));
        chk("grp_value", 32'(group_EN), 32'(g.grp));
        chk("grp_busy", 32'(busy), 32'd1);
      end
    end
    if ((sample_valid === 1'b1) || (done === 1'b1)) begin
      if (evt_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL evt_unexpected: got sample_valid=%0d done=%0d at cycle %0d, required none",
                 sample_valid, done, k);
      end else begin
        e = evt_q.pop_front();
        chk("evt_kind", 32'({done, sample_valid}), e.is_done ? 32'd2 : 32'd1);
        chk("evt_cycle", 32'(k), 32'(e.cyc));
        chk("evt_sweep", 32'(sweep_cnt), 32'(e.sw));
        chk("evt_beta", 32'(beta_idx), 32'(e.beta));
        chk("evt_busy", 32'(busy), e.is_done ? 32'd0 : 32'd1);
      end
    end
  end

  task automatic do_start(input int d, input int n, input int s);
    dwell_cycles    = 8'(d);
    num_sweeps      = 16'(n);
    sweeps_per_beta = 16'(s);
    start           = 1'b1;
    t0              = cyc;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int j);
    while ((cyc - t0) < j) @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      if ((grp_q.size() == 0) && (evt_q.size() == 0)) break;
      @(negedge clk);
    end
    chk("drain_grp_left", 32'(grp_q.size()), 32'd0);
    chk("drain_evt_left", 32'(evt_q.size()), 32'd0);
    grp_q.delete();
    evt_q.delete();
    @(negedge clk); #1;
  endtask

  task automatic chk_idle(input string tag, input int sw, input int b);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_update_en"}, 32'(update_en), 32'd0);
    chk({tag, "_group"}, 32'(group_EN), 32'd0);
    chk({tag, "_sweep"}, 32'(sweep_cnt), 32'(sw));
    chk({tag, "_beta"}, 32'(beta_idx), 32'(b));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    dwell_cycles = '0; num_sweeps = '0; sweeps_per_beta = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_idle("reset", 0, 0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_sample", 32'(sample_valid), 32'd0);

    // dwell 1, 2 sweeps, start in the first cycle after reset release
    rst = 1'b0;
    push_grps(1, 1, 10);
    push_evt(0, 5, 0, 0); push_evt(0, 10, 1, 0); push_evt(1, 11, 2, 0);
    do_start(1, 2, 0);
    wait_drain(40);
    chk_idle("runA", 2, 0);

    // dwell 3, 1 sweep; inputs changed mid-run must be ignored
    push_grps(1, 3, 15);
    push_evt(0, 15, 0, 0); push_evt(1, 16, 1, 0);
    do_start(3, 1, 0);
    dwell_cycles = 8'd7; num_sweeps = 16'd9; sweeps_per_beta = 16'd3;
    wait_drain(40);
    chk_idle("runB", 1, 0);

    // dwell 0 acts as 1; beta steps every 2 sweeps
    push_grps(1, 1, 20);
    push_evt(0, 5, 0, 0); push_evt(0, 10, 1, 0);
    push_evt(0, 15, 2, 1); push_evt(0, 20, 3, 1);
    push_evt(1, 21, 4, 2);
    do_start(0, 4, 2);
    wait_drain(60);
    chk_idle("runC", 4, 2);

    // zero sweeps: straight to FINISH
    push_evt(1, 1, 0, 0);
    do_start(2, 0, 0);
    chk("zero_busy", 32'(busy), 32'd0);
    wait_drain(10);
    chk_idle("runD", 0, 0);

    // stop during sweep 3 of 10
    push_grps(1, 1, 12);
    push_evt(0, 5, 0, 0); push_evt(0, 10, 1, 0);
    do_start(1, 10, 0);
    wait_cyc(12);
    stop = 1'b1;
    wait_cyc(13);
    chk_idle("stopped", 2, 0);
    start = 1'b1;
    wait_cyc(16);
    start = 1'b0;
    stop  = 1'b0;
    wait_cyc(18);
    chk_idle("stop_start_ignored", 2, 0);
    chk("stop_done", 32'(done), 32'd0);
    wait_drain(5);

    // reset mid-run after one sweep, then a clean run
    push_grps(1, 1, 7);
    push_evt(0, 5, 0, 0);
    do_start(1, 3, 1);
    wait_cyc(7);
    rst = 1'b1;
    wait_cyc(9);
    chk_idle("midrst", 0, 0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_left", 32'(grp_q.size() + evt_q.size()), 32'd0);
    rst = 1'b0;
    push_grps(1, 1, 5);
    push_evt(0, 5, 0, 0); push_evt(1, 6, 1, 1);
    do_start(1, 1, 1);
    wait_drain(30);
    chk_idle("runF", 1, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
